// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns four raw, bouncy, asynchronous active-low direction buttons into
//   clean single-cycle active-low move strobes for the game logic.
//   Each channel: 2-flop synchronizer -> debounce -> press detect /
//   hold-to-repeat -> pending bit. A fixed-priority arbiter
//   (up > down > left > right) issues at most one strobe per cycle.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high; clears all state
//   up_raw, down_raw, left_raw, right_raw
//              raw buttons, active-low, asynchronous to clk
//   up, down, left, right
//              registered move strobes, active-low, one cycle wide, idle high
//   btn_state  debounced pressed levels, active-high, {up, down, left, right}
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter int unsigned CNT_W           = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] btn_state
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               RPT_EN     = (REPEAT_DELAY != 0);
  localparam logic [CNT_W-1:0] RPT_LAST   = RPT_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] RPT_RELOAD =
    (REPEAT_DELAY > REPEAT_PERIOD) ? CNT_W'(REPEAT_DELAY - REPEAT_PERIOD) : '0;

  // Channel index 3..0 = up, down, left, right throughout.
  logic [3:0]       raw;
  logic [3:0]       s1_q, s1_d;
  logic [3:0]       s2_q, s2_d;
  logic [3:0]       stable_q, stable_d;
  logic [CNT_W-1:0] dcnt_q [4];
  logic [CNT_W-1:0] dcnt_d [4];
  logic [CNT_W-1:0] rcnt_q [4];
  logic [CNT_W-1:0] rcnt_d [4];
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       strobe_q, strobe_d;
  logic [3:0]       btn_state_q, btn_state_d;

  logic [3:0]       press;
  logic [3:0]       rpt;
  logic [3:0]       set;
  logic [3:0]       grant;

  assign raw = {up_raw, down_raw, left_raw, right_raw};

  always_comb begin
    s1_d        = raw;
    s2_d        = s1_q;
    stable_d    = stable_q;
    press       = '0;
    rpt         = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      dcnt_d[i] = '0;
      rcnt_d[i] = '0;
    end

    for (int unsigned i = 0; i < 4; i++) begin
      // Debounce: any return to the stable level restarts the count.
      if (s2_q[i] != stable_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
        end
      end

      press[i] = stable_q[i] & ~stable_d[i];

      // Repeat counter runs only while the button stays pressed; the
      // release edge itself already clears it.
      if (RPT_EN && !stable_q[i] && !stable_d[i]) begin
        if (rcnt_q[i] == RPT_LAST) begin
          rpt[i]    = 1'b1;
          rcnt_d[i] = RPT_RELOAD;
        end else begin
          rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
        end
      end
    end

    set = press | rpt;

    grant    = '0;
    grant[3] = pending_q[3];
    grant[2] = pending_q[2] & ~pending_q[3];
    grant[1] = pending_q[1] & ~|pending_q[3:2];
    grant[0] = pending_q[0] & ~|pending_q[3:1];

    // A new event for a channel that is already pending is absorbed, even
    // when that channel is being granted this cycle: this keeps at least one
    // idle cycle between two strobes of the same button.
    pending_d   = (pending_q & ~grant) | (~pending_q & set);
    strobe_d    = ~grant;
    btn_state_d = ~stable_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= '1;
      s2_q        <= '1;
      stable_q    <= '1;
      pending_q   <= '0;
      strobe_q    <= '1;
      btn_state_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        dcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      pending_q   <= pending_d;
      strobe_q    <= strobe_d;
      btn_state_q <= btn_state_d;
      for (int unsigned i = 0; i < 4; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  assign up        = strobe_q[3];
  assign down      = strobe_q[2];
  assign left      = strobe_q[1];
  assign right     = strobe_q[0];
  assign btn_state = btn_state_q;

endmodule
